// File: rtl/calc_defs.sv
// Shared constants for the calculator blocks: FSM encodings and default slice count.
package calc_defs;

    localparam int NIBBLES_DEFAULT = 4;
    localparam int NIBBLE_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } calc_state_t;

endpackage : calc_defs

// File: rtl/adder_4.sv
// 4-bit ripple slice used once per nibble by the serial adder.
module adder_4 (
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic       c_in,
    output logic [3:0] sum_out,
    output logic       c_out
);

    assign {c_out, sum_out} = {1'b0, a_in} + {1'b0, b_in} + {4'b0000, c_in};

endmodule : adder_4

// File: rtl/serial_adder_16.sv
// Nibble-serial add/subtract: one 4-bit slice per clock, result published only on completion.
module serial_adder_16
    import calc_defs::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   start_in,
    input  logic                   sub_in,
    input  logic [4*NIBBLES-1:0]   a_in16,
    input  logic [4*NIBBLES-1:0]   b_in16,
    output logic [4*NIBBLES-1:0]   sum_out16,
    output logic                   carry_out,
    output logic                   overflow_out,
    output logic                   busy_out,
    output logic                   done_out
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    calc_state_t      state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_q, res_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             top_cin;
    logic [W-1:0]     res_shifted;

    // Operands shift right each cycle so the slice always sees bits [3:0].
    adder_4 u_slice (
        .a_in    (a_q[3:0]),
        .b_in    (b_q[3:0]),
        .c_in    (carry_q),
        .sum_out (slice_sum),
        .c_out   (slice_cout)
    );

    // Carry into the MSB of the slice, recovered from its sum bit.
    assign top_cin     = a_q[3] ^ b_q[3] ^ slice_sum[3];
    assign res_shifted = W'({slice_sum, res_q} >> 4);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_in) begin
                    a_d     = a_in16;
                    b_d     = sub_in ? ~b_in16 : b_in16;
                    carry_d = sub_in;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                res_d   = res_shifted;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    sum_d   = res_shifted;
                    cout_d  = slice_cout;
                    ovf_d   = top_cin ^ slice_cout;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum_out16    = sum_q;
    assign carry_out    = cout_q;
    assign overflow_out = ovf_q;
    assign busy_out     = (state_q == ST_RUN);
    assign done_out     = (state_q == ST_DONE);

endmodule : serial_adder_16

// File: doc/serial_adder_16.md
SERIAL_ADDER_16 -- requirements
Module: serial_adder_16

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices; data width W = 4*NIBBLES (16 at default).
REQ-002 Clk_in  input  1  single clock; all state updates on the rising edge.
REQ-003 Rst_n_in  input  1  reset, asynchronous and active-low.
REQ-004 Start_in  input  1  request a new operation; honoured only in IDLE or DONE.
REQ-005 Sub_in  input  1  0 = A+B, 1 = A-B; sampled with Start_in.
REQ-006 A_in16  input  W  operand A; sampled with Start_in.
REQ-007 B_in16  input  W  operand B; sampled with Start_in.
REQ-008 Sum_out16  output  W  result, held until the next completion.
REQ-009 Carry_out  output  1  carry out of the top nibble; for subtraction, 1 = no borrow.
REQ-010 Overflow_out  output  1  two's-complement overflow of the W-bit result.
REQ-011 Busy_out  output  1  high while in RUN.
REQ-012 Done_out  output  1  single-cycle pulse on completion.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, when Start_in=1 at edge E0, the block SHALL capture A_in16, B_in16 (inverted when Sub_in=1) and Sub_in, set the internal carry to Sub_in, clear the nibble index, and enter RUN.
REQ-015 In RUN, each edge SHALL compute one nibble, LSB nibble first, through the 4-bit slice adder.
  - Slice carry-in: the registered carry.
  - Slice sum: stored into the internal result register.
  - Slice carry-out: registered as the next carry.
  - Nibble index: incremented.
REQ-016 At edge E(NIBBLES) (E4 at default), the block SHALL load Sum_out16, Carry_out and Overflow_out from the completed result and enter DONE.
  - Overflow = carry into the top bit XOR carry out of the top bit.
REQ-017 Sum_out16, Carry_out and Overflow_out SHALL change only at completion edges or on reset; partial results SHALL never be visible.
REQ-018 Busy_out SHALL be 1 from E0 to E(NIBBLES), and 0 otherwise.
REQ-019 Done_out SHALL be 1 for exactly the cycle following E(NIBBLES), i.e. the DONE cycle.
REQ-020 DONE SHALL return to IDLE after one cycle when Start_in=0, or go directly to RUN when Start_in=1 (back-to-back operation).
REQ-021 Start_in asserted in RUN SHALL be ignored; input changes during RUN SHALL NOT affect the result in progress.
REQ-022 Nibble-index wrap-around SHALL be prevented by the RUN-to-DONE transition; the index SHALL never exceed NIBBLES-1 while in RUN.
REQ-023 Start-to-Done latency SHALL be exactly NIBBLES+1 cycles, independent of the operand values.

Reset
REQ-024 While Rst_n_in=0 the block SHALL immediately (asynchronously) enter IDLE and force every output and internal register to 0.
  - Outputs: Sum_out16=0, Carry_out=0, Overflow_out=0, Busy_out=0, Done_out=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation without any completion pulse.
REQ-026 The first Start_in accepted after reset release SHALL behave exactly as from power-up.

Structure
REQ-027 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default NIBBLES value SHALL live in the shared calculator constants file, calc_defs.
REQ-028 The block SHALL instantiate exactly one Adder_4 as its per-nibble slice, with no other arithmetic sub-module.
  - Operand-selection muxes and carry/overflow logic SHALL be local to the block.

Verification
REQ-029 Plain addition: A=0x1234, B=0x4321, Sub=0, Start at E0 -> Done_out high in the cycle after E4; Sum=0x5555, Carry=0, Overflow=0; Busy high for 4 cycles.
REQ-030 Full ripple: A=0xFFFF, B=0x0001, Sub=0 -> Sum=0x0000, Carry=1, Overflow=0.
REQ-031 Subtraction cases:
  - 0x0005-0x0007 -> Sum=0xFFFE, Carry=0, Overflow=0.
  - 0x8000-0x0001 -> Sum=0x7FFF, Carry=1, Overflow=1.
REQ-032 Operand stability: start 0x0F0F+0x0101, then change A/B to 0xAAAA and pulse Start_in during RUN -> Sum=0x1010, exactly one Done pulse, extra Start ignored.
REQ-033 Reset mid-op: start 0x1111+0x2222 and assert Rst_n_in after E2 -> all outputs 0 and no Done pulse; after release, 0x0001+0x0001 -> Sum=0x0002 after 5 cycles.
REQ-034 Back-to-back: hold Start_in high through DONE with new operands 0x7FFF+0x0001 -> RUN re-entered with no IDLE cycle; second result Sum=0x8000, Overflow=1, two Done pulses 5 cycles apart.
